// File: rtl/clk_divider_pkg.sv
// Shared constants and helpers for the clock divider: default ratios and
// the counter-width function used to size the modulo counters.
package clk_div_pkg;

   localparam int CLK_DIV_EVEN_DEF = 4;
   localparam int CLK_DIV_ODD_DEF  = 3;

   // A modulus of 1 still needs a one-bit register to hold its single state.
   function automatic int clk_div_cnt_w(input int modulus);
      return (modulus > 1) ? $clog2(modulus) : 1;
   endfunction

endpackage

// File: rtl/clk_divider_if.sv
// Bundle of the two divided clock outputs; the divider drives it through
// the master modport and downstream consumers read it through slave.
interface clk_divider_if;

   logic clk_out_even;
   logic clk_out_odd;

   modport master (
      output clk_out_even,
      output clk_out_odd
   );

   modport slave (
      input clk_out_even,
      input clk_out_odd
   );

endinterface

// File: rtl/clk_divider_mod_counter.sv
// Posedge modulo-MOD counter with asynchronous active-high reset; wrap is
// high during the cycle in which the count sits at its terminal value.
module clk_div_mod_counter #(
   parameter int MOD = 2,
   parameter int W   = 1
) (
   input  logic         clk_in,
   input  logic         rst,
   output logic [W-1:0] cnt,
   output logic         wrap
);

   localparam logic [W-1:0] CNT_LAST = W'(MOD - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign wrap = (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d = cnt_q + W'(1);
      if (wrap) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/clk_divider.sv
// Two 50%-duty divided clocks from clk_in: an even ratio by posedge toggle and,
// when CLK_DIV_ODD_EN is defined, an odd ratio by merging a posedge/negedge pair.
module clk_divider
   import clk_div_pkg::*;
#(
   parameter int EVEN_DIV = CLK_DIV_EVEN_DEF,
   parameter int ODD_DIV  = CLK_DIV_ODD_DEF
) (
   input  logic                 clk_in,
   input  logic                 rst,
   clk_divider_if.master        out_if
);

   if ((EVEN_DIV < 2) || ((EVEN_DIV % 2) != 0)) begin : g_bad_even
      $fatal(1, "clk_divider: EVEN_DIV=%0d must be even and >= 2", EVEN_DIV);
   end

   // ---------------- even path ----------------
   localparam int CE_MOD = EVEN_DIV / 2;
   localparam int CE_W   = clk_div_cnt_w(CE_MOD);

   logic [CE_W-1:0] ce_cnt_unused;
   logic            ce_wrap;
   logic            even_q;
   logic            even_d;

   clk_div_mod_counter #(
      .MOD (CE_MOD),
      .W   (CE_W)
   ) u_ce (
      .clk_in (clk_in),
      .rst    (rst),
      .cnt    (ce_cnt_unused),
      .wrap   (ce_wrap)
   );

   always_comb begin
      even_d = even_q;
      if (ce_wrap) begin
         even_d = ~even_q;
      end
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         even_q <= 1'b0;
      end else begin
         even_q <= even_d;
      end
   end

   assign out_if.clk_out_even = even_q;

`ifdef CLK_DIV_ODD_EN
   // ---------------- odd path ----------------
   if ((ODD_DIV < 3) || ((ODD_DIV % 2) == 0)) begin : g_bad_odd
      $fatal(1, "clk_divider: ODD_DIV=%0d must be odd and >= 3", ODD_DIV);
   end

   localparam int              CO_W   = clk_div_cnt_w(ODD_DIV);
   localparam logic [CO_W-1:0] CO_CLR = CO_W'(((ODD_DIV - 1) / 2) - 1);

   logic [CO_W-1:0] co_cnt;
   logic            co_wrap;
   logic            p_q;
   logic            p_d;
   logic            n_q;

   clk_div_mod_counter #(
      .MOD (ODD_DIV),
      .W   (CO_W)
   ) u_co (
      .clk_in (clk_in),
      .rst    (rst),
      .cnt    (co_cnt),
      .wrap   (co_wrap)
   );

   // p is high for (ODD_DIV-1)/2 cycles; set and clear points never coincide.
   always_comb begin
      p_d = p_q;
      if (co_wrap) begin
         p_d = 1'b1;
      end else if (co_cnt == CO_CLR) begin
         p_d = 1'b0;
      end
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         p_q <= 1'b0;
      end else begin
         p_q <= p_d;
      end
   end

   // Half-cycle delayed copy stretches the high time by T/2 to reach 50%.
   always_ff @(negedge clk_in or posedge rst) begin
      if (rst) begin
         n_q <= 1'b0;
      end else begin
         n_q <= p_q;
      end
   end

   assign out_if.clk_out_odd = p_q | n_q;
`else
   localparam int odd_div_unused = ODD_DIV;

   assign out_if.clk_out_odd = 1'b0;
`endif

endmodule

// File: tb/tb_clk_divider.sv
// Directed bench for clk_divider: three instances cover even ratios 4/2/10 and
// odd ratios 3/5/7, checked against hand-derived first-rise/period/high times.
module tb_clk_divider;

   logic clk_in = 1'b0;
   logic rst    = 1'b1;

   int check_cnt = 0;
   int pass_cnt  = 0;
   int fail_cnt  = 0;

   always #10 clk_in = ~clk_in;

   clk_divider_if if0 ();
   clk_divider_if if1 ();
   clk_divider_if if2 ();

   clk_divider #(.EVEN_DIV(4),  .ODD_DIV(3)) dut0 (.clk_in(clk_in), .rst(rst), .out_if(if0));
   clk_divider #(.EVEN_DIV(2),  .ODD_DIV(5)) dut1 (.clk_in(clk_in), .rst(rst), .out_if(if1));
   clk_divider #(.EVEN_DIV(10), .ODD_DIV(7)) dut2 (.clk_in(clk_in), .rst(rst), .out_if(if2));

   // Hand-computed waveform timing relative to reset release on a negedge
   // (first posedge after release comes 10 later):
   //   even4 : rise +30,  period 80,  high 40
   //   even2 : rise +10,  period 40,  high 20
   //   even10: rise +90,  period 200, high 100
   //   odd3  : rise +50,  period 60,  high 30
   //   odd5  : rise +90,  period 100, high 50
   //   odd7  : rise +130, period 140, high 70
   function automatic logic exp_wave(input longint t, input longint base,
                                     input longint rise, input longint per,
                                     input longint hi);
      longint d;
      d = t - base - rise;
      if (d < 0) return 1'b0;
      return ((d % per) < hi) ? 1'b1 : 1'b0;
   endfunction

   function automatic logic exp_odd(input longint t, input longint base,
                                    input longint rise, input longint per,
                                    input longint hi);
`ifdef CLK_DIV_ODD_EN
      return exp_wave(t, base, rise, per, hi);
`else
      return (t < 0 && base < 0 && rise < 0 && per < 0 && hi < 0) ? 1'b1 : 1'b0;
`endif
   endfunction

   task automatic wait_until(input longint t);
      if (t > longint'($time)) #(t - longint'($time));
   endtask

   task automatic check(input string tag, input logic obs, input logic exp);
      check_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_even4"},  if0.clk_out_even, 1'b0);
      check({tag, "_even2"},  if1.clk_out_even, 1'b0);
      check({tag, "_even10"}, if2.clk_out_even, 1'b0);
      check({tag, "_odd3"},   if0.clk_out_odd,  1'b0);
      check({tag, "_odd5"},   if1.clk_out_odd,  1'b0);
      check({tag, "_odd7"},   if2.clk_out_odd,  1'b0);
   endtask

   task automatic check_run(input string tag, input longint base);
      longint t;
      t = longint'($time);
      check({tag, "_even4"},  if0.clk_out_even, exp_wave(t, base, 30,  80,  40));
      check({tag, "_even2"},  if1.clk_out_even, exp_wave(t, base, 10,  40,  20));
      check({tag, "_even10"}, if2.clk_out_even, exp_wave(t, base, 90,  200, 100));
      check({tag, "_odd3"},   if0.clk_out_odd,  exp_odd(t, base, 50,  60,  30));
      check({tag, "_odd5"},   if1.clk_out_odd,  exp_odd(t, base, 90,  100, 50));
      check({tag, "_odd7"},   if2.clk_out_odd,  exp_odd(t, base, 130, 140, 70));
   endtask

   initial begin
      // Reset hold: all outputs 0 (not X) from after the first clock edge.
      for (int i = 0; i < 19; i++) begin
         wait_until(15 + 10 * i);
         check_all_zero("rst_hold");
      end

      wait_until(200);
      rst = 1'b0;

      // Sample midway between clk_in edges over 20 even4 periods.
      for (int i = 0; i < 160; i++) begin
         wait_until(205 + 10 * i);
         check_run("run1", 200);
      end

      // 1830 is the posedge clearing p for odd3, so at 1834 it is high via n only.
      wait_until(1834);
      check("pre_rst_odd3",  if0.clk_out_odd,  exp_odd(1834, 200, 50, 60, 30));
      check("pre_rst_even4", if0.clk_out_even, exp_wave(1834, 200, 30, 80, 40));

      wait_until(1835);
      rst = 1'b1;
      #1;
      check_all_zero("mid_rst");

      wait_until(1995);
      check_all_zero("rst_held");

      wait_until(2000);
      rst = 1'b0;

      for (int i = 0; i < 60; i++) begin
         wait_until(2005 + 10 * i);
         check_run("run2", 2000);
      end

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
